// File: rtl/gray_chk_pkg.sv
// rtl/gray_chk_pkg.sv - shared types, constants and Gray decode for gray_sequence_checker
package gray_chk_pkg;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        TRACK  = 2'd1,
        RESYNC = 2'd2
    } chk_state_e;

    localparam int SYNC_DEPTH_ON  = 3;
    localparam int SYNC_DEPTH_OFF = 1;
    localparam int GRAY_MAX_W     = 32;

    // Callers zero-extend narrower codes; leading zeros decode to leading zeros,
    // so the low W bits of the result are the W-bit binary value.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// rtl/gray2bin_conv.sv - combinational W-bit Gray to binary converter
module gray2bin_conv
    import gray_chk_pkg::*;
#(
    parameter int W = 3
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    assign bin = W'(gray2bin(GRAY_MAX_W'(gray)));

endmodule

// File: rtl/gray_sequence_checker.sv
// rtl/gray_sequence_checker.sv - Gray count step checker; GRAY_CHK_SYNC_EN adds a 2-flop input synchronizer
module gray_sequence_checker
    import gray_chk_pkg::*;
#(
    parameter int MOD_VALUE = 8,
    parameter int ERR_CNT_W = 8,
    localparam int W = $clog2(MOD_VALUE)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [W-1:0]         gray_in,
    input  logic                 clear_err,
    output logic [W-1:0]         bin_out,
    output logic                 bin_valid,
    output logic                 step_pulse,
    output logic                 wrap_pulse,
    output logic                 err_pulse,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count
);

    if (MOD_VALUE < 2 || (MOD_VALUE & (MOD_VALUE - 1)) != 0) begin : g_bad_mod
        $error("gray_sequence_checker: MOD_VALUE must be a power of two >= 2");
    end

`ifdef GRAY_CHK_SYNC_EN
    localparam int DEPTH = SYNC_DEPTH_ON;
`else
    localparam int DEPTH = SYNC_DEPTH_OFF;
`endif

    logic [W-1:0]         g_s_q;
    logic [W-1:0]         bin_s;
    logic [W-1:0]         delta;
    logic [W-1:0]         ref_q, ref_d;
    logic [1:0]           fill_q, fill_d;
    chk_state_e           state_q, state_d;
    logic                 valid_q, valid_d;
    logic                 step_q, step_d;
    logic                 wrap_q, wrap_d;
    logic                 err_q, err_d;
    logic                 sticky_q, sticky_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

`ifdef GRAY_CHK_SYNC_EN
    logic [W-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= '0;
            sync2_q <= '0;
            g_s_q   <= '0;
        end else begin
            sync1_q <= gray_in;
            sync2_q <= sync1_q;
            g_s_q   <= sync2_q;
        end
    end
`else
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            g_s_q <= '0;
        end else begin
            g_s_q <= gray_in;
        end
    end
`endif

    gray2bin_conv #(.W(W)) u_conv (
        .gray (g_s_q),
        .bin  (bin_s)
    );

    assign delta = bin_s - ref_q;

    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        ref_d    = ref_q;
        valid_d  = valid_q;
        step_d   = 1'b0;
        wrap_d   = 1'b0;
        err_d    = 1'b0;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;

        if (clear_err) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end

        case (state_q)
            INIT: begin
                // Wait until the sample register holds a real post-reset value.
                if (fill_q == 2'(DEPTH)) begin
                    ref_d   = bin_s;
                    valid_d = 1'b1;
                    state_d = TRACK;
                end else begin
                    fill_d = fill_q + 2'd1;
                end
            end
            TRACK: begin
                if (delta == W'(1)) begin
                    ref_d  = bin_s;
                    step_d = 1'b1;
                    wrap_d = (ref_q == {W{1'b1}});
                end else if (delta != '0) begin
                    ref_d    = bin_s;
                    err_d    = 1'b1;
                    sticky_d = 1'b1;
                    // An error on the same edge as clear_err still counts once.
                    if (clear_err) begin
                        cnt_d = ERR_CNT_W'(1);
                    end else if (cnt_q != {ERR_CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + ERR_CNT_W'(1);
                    end
                    state_d = RESYNC;
                end
            end
            RESYNC: begin
                ref_d   = bin_s;
                state_d = TRACK;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= INIT;
            fill_q   <= '0;
            ref_q    <= '0;
            valid_q  <= 1'b0;
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            ref_q    <= ref_d;
            valid_q  <= valid_d;
            step_q   <= step_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bin_out    = ref_q;
    assign bin_valid  = valid_q;
    assign step_pulse = step_q;
    assign wrap_pulse = wrap_q;
    assign err_pulse  = err_q;
    assign err_sticky = sticky_q;
    assign err_count  = cnt_q;

endmodule

// File: tb/tb_gray_sequence_checker.sv
// tb/tb_gray_sequence_checker.sv - directed self-checking bench for gray_sequence_checker
module tb_gray_sequence_checker;

`ifdef GRAY_CHK_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int NVEC = 21;

    typedef struct {
        logic [2:0] gray;
        logic [2:0] bin;
        logic       step;
        logic       wrap;
        logic       err;
        logic       sticky;
        logic [7:0] cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic [2:0] gray_in;
    logic       clear_err;
    logic [2:0] bin_out;
    logic       bin_valid;
    logic       step_pulse;
    logic       wrap_pulse;
    logic       err_pulse;
    logic       err_sticky;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;
    vec_t vecs[NVEC];

    gray_sequence_checker #(.MOD_VALUE(8), .ERR_CNT_W(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .gray_in    (gray_in),
        .clear_err  (clear_err),
        .bin_out    (bin_out),
        .bin_valid  (bin_valid),
        .step_pulse (step_pulse),
        .wrap_pulse (wrap_pulse),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " bin_out"},    32'(bin_out),    0);
        chk({tag, " bin_valid"},  32'(bin_valid),  0);
        chk({tag, " step_pulse"}, 32'(step_pulse), 0);
        chk({tag, " wrap_pulse"}, 32'(wrap_pulse), 0);
        chk({tag, " err_pulse"},  32'(err_pulse),  0);
        chk({tag, " err_sticky"}, 32'(err_sticky), 0);
        chk({tag, " err_count"},  32'(err_count),  0);
    endtask

    function automatic vec_t mk(input int g, input int b, input int st, input int wr,
                                input int er, input int sk, input int cn);
        vec_t v;
        v.gray   = 3'(g);
        v.bin    = 3'(b);
        v.step   = st[0];
        v.wrap   = wr[0];
        v.err    = er[0];
        v.sticky = sk[0];
        v.cnt    = 8'(cn);
        return v;
    endfunction

    initial begin
        //          gray bin stp wrp err stk cnt
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 1, 0, 0, 0, 0);
        vecs[2]  = mk(3, 2, 1, 0, 0, 0, 0);
        vecs[3]  = mk(2, 3, 1, 0, 0, 0, 0);
        vecs[4]  = mk(6, 4, 1, 0, 0, 0, 0);
        vecs[5]  = mk(7, 5, 1, 0, 0, 0, 0);
        vecs[6]  = mk(5, 6, 1, 0, 0, 0, 0);
        vecs[7]  = mk(4, 7, 1, 0, 0, 0, 0);
        vecs[8]  = mk(0, 0, 1, 1, 0, 0, 0);
        vecs[9]  = mk(1, 1, 1, 0, 0, 0, 0);
        vecs[10] = mk(3, 2, 1, 0, 0, 0, 0);
        vecs[11] = mk(3, 2, 0, 0, 0, 0, 0);
        vecs[12] = mk(3, 2, 0, 0, 0, 0, 0);
        vecs[13] = mk(3, 2, 0, 0, 0, 0, 0);
        vecs[14] = mk(3, 2, 0, 0, 0, 0, 0);
        vecs[15] = mk(1, 1, 0, 0, 1, 1, 1);
        vecs[16] = mk(1, 1, 0, 0, 0, 1, 1);
        vecs[17] = mk(6, 4, 0, 0, 1, 1, 2);
        vecs[18] = mk(6, 4, 0, 0, 0, 1, 2);
        vecs[19] = mk(7, 5, 1, 0, 0, 1, 2);
        vecs[20] = mk(5, 6, 1, 0, 0, 1, 2);

        rstn      = 1'b0;
        gray_in   = 3'd0;
        clear_err = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rstn = 1'b1;

        // vecs[k] is driven before edge k and shows on the outputs after edge k+LAT
        for (int i = 0; i < NVEC + LAT; i++) begin
            gray_in = vecs[(i < NVEC) ? i : NVEC - 1].gray;
            tick();
            if (i < LAT) begin
                chk($sformatf("fill[%0d] bin_valid", i), 32'(bin_valid), 0);
            end else begin
                chk($sformatf("v%0d bin_valid", i - LAT),  32'(bin_valid),  1);
                chk($sformatf("v%0d bin_out", i - LAT),    32'(bin_out),    32'(vecs[i-LAT].bin));
                chk($sformatf("v%0d step_pulse", i - LAT), 32'(step_pulse), 32'(vecs[i-LAT].step));
                chk($sformatf("v%0d wrap_pulse", i - LAT), 32'(wrap_pulse), 32'(vecs[i-LAT].wrap));
                chk($sformatf("v%0d err_pulse", i - LAT),  32'(err_pulse),  32'(vecs[i-LAT].err));
                chk($sformatf("v%0d err_sticky", i - LAT), 32'(err_sticky), 32'(vecs[i-LAT].sticky));
                chk($sformatf("v%0d err_count", i - LAT),  32'(err_count),  32'(vecs[i-LAT].cnt));
            end
        end

        // clear_err alone
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("clear err_sticky", 32'(err_sticky), 0);
        chk("clear err_count",  32'(err_count),  0);
        chk("clear bin_out",    32'(bin_out),    6);

        // Error (bin 6 -> 0) to make the count nonzero
        gray_in = 3'd0;
        repeat (LAT + 1) tick();
        chk("pre err_pulse", 32'(err_pulse), 1);
        chk("pre err_count", 32'(err_count), 1);
        tick();
        chk("pre resync err_pulse", 32'(err_pulse), 0);

        // Error (bin 0 -> 4) on the same edge as clear_err
        gray_in = 3'd6;
        repeat (LAT) tick();
        chk("coinc quiet err_pulse", 32'(err_pulse), 0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("coinc err_pulse",  32'(err_pulse),  1);
        chk("coinc err_sticky", 32'(err_sticky), 1);
        chk("coinc err_count",  32'(err_count),  1);
        chk("coinc bin_out",    32'(bin_out),    4);
        tick();

        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("sat start err_count", 32'(err_count), 0);

        // 260 illegal jumps bin 4 <-> 0, each held across its resync cycle
        for (int k = 0; k < 260; k++) begin
            gray_in = (k % 2 == 0) ? 3'd0 : 3'd6;
            tick();
            tick();
        end
        repeat (LAT + 1) tick();
        chk("sat err_count",  32'(err_count),  255);
        chk("sat err_sticky", 32'(err_sticky), 1);
        chk("sat bin_valid",  32'(bin_valid),  1);

        // Asynchronous reset between edges
        #3;
        rstn = 1'b0;
        #1;
        chk_all_zero("async rst");
        tick();
        gray_in = 3'd3;
        rstn    = 1'b1;
        repeat (LAT) tick();
        chk("rerun fill bin_valid", 32'(bin_valid), 0);
        tick();
        chk("rerun bin_valid", 32'(bin_valid), 1);
        chk("rerun bin_out",   32'(bin_out),   2);
        chk("rerun err_count", 32'(err_count), 0);
        tick();
        chk("rerun hold step_pulse", 32'(step_pulse), 0);
        chk("rerun hold err_pulse",  32'(err_pulse),  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_sequence_checker.md
# gray_sequence_checker

Downstream consumer of the Gray-code UP counter. Samples a Gray count each cycle (optionally through a 2-flop synchronizer), converts it to binary, and checks every step for legality: either unchanged or +1 modulo MOD_VALUE. It outputs the decoded count, step and wrap strobes, and error status with a saturating error counter. Sits between the Gray counter and any logic that consumes binary occupancy or position.

## Interface
- MOD_VALUE, 8, counter modulus; must be a power of two ≥ 2 (elaboration error otherwise); W = $clog2(MOD_VALUE)
- ERR_CNT_W, 8, error counter width
- clk  input  1  single clock, all flops rising-edge
- rstn  input  1  reset, asynchronous, active-low
- gray_in  input  W  Gray-coded count from upstream counter
- clear_err  input  1  synchronous clear of err_sticky and err_count
- bin_out  output  W  decoded binary count of last accepted sample
- bin_valid  output  1  high once the reference is established
- step_pulse  output  1  one-cycle strobe: count advanced by exactly 1
- wrap_pulse  output  1  one-cycle strobe: advance was MOD_VALUE-1 → 0 (coincides with step_pulse)
- err_pulse  output  1  one-cycle strobe: illegal transition
- err_sticky  output  1  set on any error, held until clear_err
- err_count  output  ERR_CNT_W  saturating error count

## Operation
- Datapath: [sync1 → sync2, only with macro] → g_s (sample register) → compare against reference ref (binary) → registered outputs.
- Gray→binary: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i].
- delta = (bin(g_s) − ref) mod MOD_VALUE, W-bit wrap arithmetic.
- FSM states:
  - INIT: entered on reset. Fill counter counts edges up to DEPTH (1 without sync, 3 with sync). On the next edge: ref ← bin(g_s), bin_out ← bin(g_s), bin_valid ← 1, go to TRACK. No checks and no strobes in INIT.
  - TRACK, delta 0: hold; no strobes.
  - TRACK, delta 1: ref/bin_out ← new value; step_pulse. wrap_pulse also, if old ref = MOD_VALUE−1.
  - TRACK, any other delta (including backward step MOD_VALUE−1): err_pulse; err_sticky ← 1; err_count += 1 (saturates at 2^ERR_CNT_W−1); ref/bin_out ← new value; go to RESYNC.
  - RESYNC: one cycle. ref ← bin(g_s) with no check, then TRACK. bin_valid stays 1.
- clear_err and an error on the same edge: the error wins. err_sticky = 1, err_count = 1.
- clear_err alone: err_sticky ← 0, err_count ← 0 next edge.
- Reset values: bin_out 0, bin_valid 0, all strobes 0, err_sticky 0, err_count 0, state INIT, sync/sample flops 0.
- rstn asserted mid-operation: all of the above immediately (asynchronously). The INIT fill restarts after release.

## Timing
- gray_in sampled at edge n. Outputs reflect it after edge n+1 (no sync) or n+3 (sync).
- bin_valid rises after edge 2 (no sync) or edge 4 (sync) following rstn release.
- Strobes are high for exactly one cycle per event. Back-to-back legal steps give continuous step_pulse.
- err_count and err_sticky update on the same edge as err_pulse.

## Configuration
- GRAY_CHK_SYNC_EN defined: two synchronizer flops precede g_s. DEPTH = 3; latency 3 cycles.
- Not defined: gray_in is registered directly into g_s. DEPTH = 1; latency 1 cycle.
- All other behaviour is identical.

## Structure
- Package gray_chk_pkg holds:
  - state enum {INIT, TRACK, RESYNC}
  - gray2bin function, width-parameterised via W
  - constants SYNC_DEPTH_ON = 3 and SYNC_DEPTH_OFF = 1
- One sub-module, gray2bin_conv: combinational, W parameter, used on g_s.
- FSM, fill counter, compare logic and error counter stay in the top module.

## Test plan
All scenarios use MOD_VALUE = 8 and run in both macro builds.
- Legal sequence: reset, then gray_in 0,1,3,2,6,7,5,4,0 one per cycle.
  - Expect bin_out 0..7,0.
  - Expect step_pulse on each change, wrap_pulse once at 7→0, err_count 0.
- Hold: gray_in held at 3 for 5 cycles.
  - Expect bin_out 2 stable, no strobes.
- Illegal jump: gray 1 → 6 (bin 1 → 4).
  - Expect one err_pulse, err_sticky 1, err_count 1, bin_out 4.
  - Then gray 7 (bin 5): step_pulse, no new error.
- Backward step: gray 3 → 1 (bin 2 → 1).
  - Expect err_pulse.
- clear_err coincident with an error: expect err_count 1 and err_sticky 1.
- Saturation: drive 260 alternating illegal jumps; expect err_count 255.
- Mid-stream reset: rstn low between edges.
  - Expect all outputs 0 immediately.
  - Expect bin_valid back high after edge 2 (no sync) or edge 4 (sync).
